// File: rtl/hermes_src_pkg.sv
// Shared types for the Hermes stream source: framer states, FIFO entry layout, size field width.
package hermes_src_pkg;

  localparam int SIZE_FIELD_W = 16;
  localparam int FLIT_W       = 32;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    SIZE    = 2'd1,
    PAYLOAD = 2'd2
  } framer_state_e;

  typedef struct packed {
    logic              eop;
    logic [FLIT_W-1:0] data;
  } src_entry_t;

endpackage

// File: rtl/hermes_src_fifo.sv
// Synchronous FIFO with registered full/empty; head visible the cycle after the first push.
// Push is ignored while full (even alongside a pop); pop is ignored while empty.
module hermes_src_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i && !r_full;
  assign w_pop  = pop_i && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset: the registered empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

// File: rtl/hermes_stream_source.sv
// Host valid/ready stream to Hermes credit link, framing words by the size flit; one-cycle FIFO latency.
// s_ready_o follows the registered FIFO full flag; the link head holds while credit is absent.
module hermes_stream_source
  import hermes_src_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PAYLOAD = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [FLIT_SIZE-1:0] s_data_i,
  input  logic                 s_last_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic [15:0]          pkt_count_o,
  output logic                 err_len_o,
  output logic                 err_size_o,
  input  logic                 err_clr_i
);

  localparam int ENTRY_W = FLIT_SIZE + 1;

  framer_state_e           r_state;
  framer_state_e           w_state_nxt;
  logic [SIZE_FIELD_W-1:0] r_rem;
  logic [SIZE_FIELD_W-1:0] w_rem_nxt;
  logic [SIZE_FIELD_W-1:0] w_size;
  logic                    w_eop;
  logic                    w_size_err;
  logic                    w_len_err;
  logic                    w_acc;
  logic                    w_full;
  logic                    w_empty;
  logic [ENTRY_W-1:0]      w_head;
  logic                    w_link_xfer;
  logic                    r_ready_en;
  logic [15:0]             r_pkt_count;
  logic                    r_err_len;
  logic                    r_err_size;

  // Ready stays low until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ready_en <= 1'b0;
    else         r_ready_en <= 1'b1;
  end

  assign s_ready_o = r_ready_en && !w_full;
  assign w_acc     = s_valid_i && s_ready_o;
  assign w_size    = s_data_i[SIZE_FIELD_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= HDR;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_eop       = 1'b0;
    w_size_err  = 1'b0;
    if (w_acc) begin
      case (r_state)
        HDR: w_state_nxt = SIZE;
        SIZE: begin
          w_size_err = (w_size > SIZE_FIELD_W'(MAX_PAYLOAD));
          if (w_size == '0) begin
            w_eop       = 1'b1;
            w_state_nxt = HDR;
          end else begin
            w_rem_nxt   = w_size;
            w_state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          w_rem_nxt = r_rem - SIZE_FIELD_W'(1);
          if (r_rem == SIZE_FIELD_W'(1)) begin
            w_eop       = 1'b1;
            w_state_nxt = HDR;
          end
        end
        default: w_state_nxt = HDR;
      endcase
    end
  end

  // The host's last flag is only audited; the computed eop defines the packet.
  assign w_len_err = w_acc && (s_last_i != w_eop);

  hermes_src_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_acc),
    .data_i  ({w_eop, s_data_i}),
    .pop_i   (credit_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign tx_o        = !w_empty;
  assign data_o      = w_head[FLIT_SIZE-1:0];
  assign w_link_xfer = tx_o && credit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pkt_count <= '0;
      r_err_len   <= 1'b0;
      r_err_size  <= 1'b0;
    end else begin
      if (w_link_xfer && w_head[FLIT_SIZE]) r_pkt_count <= r_pkt_count + 16'd1;
      if (w_len_err)      r_err_len <= 1'b1;
      else if (err_clr_i) r_err_len <= 1'b0;
      if (w_size_err)     r_err_size <= 1'b1;
      else if (err_clr_i) r_err_size <= 1'b0;
    end
  end

  assign busy_o      = (r_state != HDR) || !w_empty;
  assign pkt_count_o = r_pkt_count;
  assign err_len_o   = r_err_len;
  assign err_size_o  = r_err_size;

endmodule

// File: tb/tb_hermes_stream_source.sv
// Randomised bench for hermes_stream_source against a packet-level reference model.
module tb_hermes_stream_source;

  localparam int FLIT  = 32;
  localparam int DEPTH = 8;
  localparam int MAXP  = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            s_valid_i;
  logic            s_ready_o;
  logic [FLIT-1:0] s_data_i;
  logic            s_last_i;
  logic            tx_o;
  logic            credit_i;
  logic [FLIT-1:0] data_o;
  logic            busy_o;
  logic [15:0]     pkt_count_o;
  logic            err_len_o;
  logic            err_size_o;
  logic            err_clr_i;

  always #5 clk_i = ~clk_i;

  hermes_stream_source #(
    .FLIT_SIZE   (FLIT),
    .FIFO_DEPTH  (DEPTH),
    .MAX_PAYLOAD (MAXP)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .tx_o        (tx_o),
    .credit_i    (credit_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .pkt_count_o (pkt_count_o),
    .err_len_o   (err_len_o),
    .err_size_o  (err_size_o),
    .err_clr_i   (err_clr_i)
  );

  int checks = 0;
  int errors = 0;
  int credit_mode = 0;   // 0: always on, 1: random, 2: withheld
  int gap_max = 0;
  int acc_cnt = 0;
  int mdl_pkts = 0;
  logic exp_err_len = 1'b0;
  logic exp_err_size = 1'b0;
  logic [47:0] rcv_q[$];
  logic [47:0] exp_q[$];
  logic [31:0] pw[$];
  logic        pl[$];

  always @(posedge clk_i) begin
    #1;
    case (credit_mode)
      0:       credit_i = 1'b1;
      1:       credit_i = ($urandom_range(0, 3) != 0);
      default: credit_i = 1'b0;
    endcase
  end

  // Each link transfer is logged with the packet count seen just before it.
  always @(negedge clk_i) begin
    if (rst_ni && tx_o && credit_i) rcv_q.push_back({pkt_count_o, data_o});
  end

  task automatic send_word(input logic [31:0] d, input logic l, output bit ok);
    int n = 0;
    ok = 1'b0;
    s_valid_i = 1'b1; s_data_i = d; s_last_i = l;
    while (n < 500) begin
      @(negedge clk_i);
      if (s_ready_o) begin ok = 1'b1; break; end
      n++;
    end
    if (ok) begin @(posedge clk_i); #1; acc_cnt++; end
    s_valid_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic build(input logic [31:0] hdr, input int n);
    logic [15:0] up = 16'($urandom());
    pw.delete(); pl.delete();
    pw.push_back(hdr);
    pw.push_back({up, 16'(n)});
    for (int i = 0; i < n; i++) pw.push_back($urandom());
    for (int i = 0; i < pw.size(); i++) pl.push_back(i == pw.size() - 1);
  endtask

  // Packet = header, size N, N payload words; the word at index 1+N ends it.
  task automatic model_pkt();
    int n = int'(pw[1][15:0]);
    if (n > MAXP) exp_err_size = 1'b1;
    for (int i = 0; i < pw.size(); i++) begin
      logic eop = (i == 1 + n);
      exp_q.push_back({16'(mdl_pkts), pw[i]});
      if (pl[i] != eop) exp_err_len = 1'b1;
      if (eop) mdl_pkts = (mdl_pkts + 1) % 65536;
    end
  endtask

  task automatic send_pkt(output bit ok);
    bit w;
    ok = 1'b1;
    model_pkt();
    foreach (pw[i]) begin
      send_word(pw[i], pl[i], w);
      ok &= w;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk_i); #1; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      if (!busy_o && !tx_o) begin ok = 1'b1; break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1; @(posedge clk_i); #1; err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; err_clr_i = 1'b0; credit_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({s_ready_o, tx_o, busy_o, err_len_o, err_size_o, pkt_count_o, data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b tx=%0b busy=%0b el=%0b es=%0b cnt=%0d dat=%h want all zero",
               s_ready_o, tx_o, busy_o, err_len_o, err_size_o, pkt_count_o, data_o);
    end
    @(posedge clk_i); #1; rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", s_ready_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    bit ok, w;
    credit_mode = 0;
    pw = '{32'h0000_0102, 32'h0000_0003, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    pl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    model_pkt();
    send_word(pw[0], pl[0], ok);
    @(negedge clk_i);
    checks++;
    if (!(tx_o === 1'b1 && data_o === pw[0])) begin
      errors++; $display("FAIL basic_latency got tx=%0b data=%h want tx=1 data=%h", tx_o, data_o, pw[0]);
    end
    @(posedge clk_i); #1;
    for (int i = 1; i < 5; i++) begin send_word(pw[i], pl[i], w); ok &= w; end
    wait_idle(w);
    checks++; if (!(ok && w)) begin errors++; $display("FAIL basic_timeout got ok=%0b idle=%0b want 1 1", ok, w); end
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count_o !== 16'(mdl_pkts)) begin errors++; $display("FAIL basic_pkts got %0d want %0d", pkt_count_o, mdl_pkts); end
    checks++; if ({err_len_o, err_size_o} !== {exp_err_len, exp_err_size}) begin errors++; $display("FAIL basic_err got %b%b want %b%b", err_len_o, err_size_o, exp_err_len, exp_err_size); end
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok, w;
    credit_mode = 2;
    repeat (2) begin @(posedge clk_i); #1; end
    acc_cnt = 0;
    build(32'h0000_0BB0, 10);
    fork
      send_pkt(ok);
      begin
        repeat (10) @(negedge clk_i);
        checks++; if (data_o !== pw[0]) begin errors++; $display("FAIL bp_head_mid got %h want %h", data_o, pw[0]); end
        repeat (10) @(negedge clk_i);
        checks++;
        if (!(s_ready_o === 1'b0 && acc_cnt == DEPTH && tx_o === 1'b1 && data_o === pw[0])) begin
          errors++;
          $display("FAIL bp_stall got rdy=%0b acc=%0d tx=%0b data=%h want rdy=0 acc=%0d tx=1 data=%h",
                   s_ready_o, acc_cnt, tx_o, data_o, DEPTH, pw[0]);
        end
        credit_mode = 0;
      end
    join
    wait_idle(w);
    checks++; if (!(ok && w)) begin errors++; $display("FAIL bp_timeout got ok=%0b idle=%0b want 1 1", ok, w); end
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count_o !== 16'(mdl_pkts)) begin errors++; $display("FAIL bp_pkts got %0d want %0d", pkt_count_o, mdl_pkts); end
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic test_zero_size();
    bit ok, w;
    build(32'h0000_0E00, 0);
    send_pkt(ok);
    wait_idle(w);
    checks++; if (!(ok && w)) begin errors++; $display("FAIL zero_timeout got ok=%0b idle=%0b want 1 1", ok, w); end
    checks++; if (rcv_q.size() != 2) begin errors++; $display("FAIL zero_count got %0d want 2", rcv_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count_o !== 16'(mdl_pkts)) begin errors++; $display("FAIL zero_pkts got %0d want %0d", pkt_count_o, mdl_pkts); end
    checks++; if ({err_len_o, err_size_o} !== 2'b00) begin errors++; $display("FAIL zero_err got %b%b want 00", err_len_o, err_size_o); end
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic test_early_last();
    bit ok, w, w2;
    build(32'h0000_0EA1, 4);
    pl[3] = 1'b1;
    send_pkt(ok);
    wait_idle(w);
    checks++; if (!(ok && w)) begin errors++; $display("FAIL early_timeout got ok=%0b idle=%0b want 1 1", ok, w); end
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL early_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL early_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if ({err_len_o, err_size_o} !== {exp_err_len, exp_err_size}) begin errors++; $display("FAIL early_err got %b%b want %b%b", err_len_o, err_size_o, exp_err_len, exp_err_size); end
    pulse_clr(); exp_err_len = 1'b0;
    @(negedge clk_i);
    checks++; if (err_len_o !== 1'b0) begin errors++; $display("FAIL early_clear got %0b want 0", err_len_o); end
    @(posedge clk_i); #1;
    rcv_q.delete(); exp_q.delete();
    // Clear in the same cycle as a mismatching last: the set must win.
    build(32'h0000_0D0D, 0);
    pl[0] = 1'b1;
    model_pkt();
    err_clr_i = 1'b1;
    send_word(pw[0], pl[0], w);
    err_clr_i = 1'b0;
    send_word(pw[1], pl[1], w2);
    wait_idle(ok);
    checks++; if (err_len_o !== exp_err_len) begin errors++; $display("FAIL early_setdom got %0b want %0b", err_len_o, exp_err_len); end
    checks++; if (pkt_count_o !== 16'(mdl_pkts)) begin errors++; $display("FAIL early_pkts got %0d want %0d", pkt_count_o, mdl_pkts); end
    pulse_clr(); exp_err_len = 1'b0;
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic test_oversize();
    bit ok, w;
    int p0 = mdl_pkts;
    build(32'h0000_0F40, 40);
    send_pkt(ok);
    wait_idle(w);
    checks++; if (!(ok && w)) begin errors++; $display("FAIL over_timeout got ok=%0b idle=%0b want 1 1", ok, w); end
    checks++; if (rcv_q.size() != 42) begin errors++; $display("FAIL over_count got %0d want 42", rcv_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL over_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count_o !== 16'(p0 + 1)) begin errors++; $display("FAIL over_pkts got %0d want %0d", pkt_count_o, p0 + 1); end
    checks++; if ({err_len_o, err_size_o} !== 2'b01) begin errors++; $display("FAIL over_err got %b%b want 01", err_len_o, err_size_o); end
    pulse_clr(); exp_err_size = 1'b0;
    @(negedge clk_i);
    checks++; if (err_size_o !== 1'b0) begin errors++; $display("FAIL over_clear got %0b want 0", err_size_o); end
    @(posedge clk_i); #1;
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok, w, all_ok;
    all_ok = 1'b1;
    credit_mode = 1; gap_max = 2;
    for (int p = 0; p < 25; p++) begin
      build($urandom(), $urandom_range(0, MAXP));
      send_pkt(ok);
      all_ok &= ok;
    end
    credit_mode = 0; gap_max = 0;
    wait_idle(w);
    checks++; if (!(all_ok && w)) begin errors++; $display("FAIL rand_timeout got ok=%0b idle=%0b want 1 1", all_ok, w); end
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count_o !== 16'(mdl_pkts)) begin errors++; $display("FAIL rand_pkts got %0d want %0d", pkt_count_o, mdl_pkts); end
    checks++; if ({err_len_o, err_size_o} !== {exp_err_len, exp_err_size}) begin errors++; $display("FAIL rand_err got %b%b want %b%b", err_len_o, err_size_o, exp_err_len, exp_err_size); end
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    bit ok, w;
    credit_mode = 2;
    repeat (2) begin @(posedge clk_i); #1; end
    build(32'h0000_0A5A, 10);
    for (int i = 0; i < 5; i++) send_word(pw[i], pl[i], w);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_ready_o, tx_o, busy_o, pkt_count_o} !== '0) begin
      errors++; $display("FAIL rstmid_during got rdy=%0b tx=%0b busy=%0b cnt=%0d want 0 0 0 0", s_ready_o, tx_o, busy_o, pkt_count_o);
    end
    @(posedge clk_i); #1; rst_ni = 1'b1;
    mdl_pkts = 0; exp_err_len = 1'b0; exp_err_size = 1'b0;
    rcv_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk_i);
    checks++;
    if ({tx_o, busy_o, pkt_count_o} !== '0) begin
      errors++; $display("FAIL rstmid_after got tx=%0b busy=%0b cnt=%0d want 0 0 0", tx_o, busy_o, pkt_count_o);
    end
    @(posedge clk_i); #1;
    credit_mode = 0;
    build(32'h0000_0123, 1);
    send_pkt(ok);
    wait_idle(w);
    checks++; if (!(ok && w)) begin errors++; $display("FAIL rstmid_timeout got ok=%0b idle=%0b want 1 1", ok, w); end
    checks++; if (rcv_q.size() != 3) begin errors++; $display("FAIL rstmid_count got %0d want 3", rcv_q.size()); end
    foreach (exp_q[i]) if (i < rcv_q.size()) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_flit%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
    checks++; if ({pkt_count_o, err_len_o, err_size_o} !== {16'd1, 2'b00}) begin
      errors++; $display("FAIL rstmid_state got cnt=%0d el=%0b es=%0b want 1 0 0", pkt_count_o, err_len_o, err_size_o);
    end
    rcv_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_size();
    test_early_last();
    test_oversize();
    test_random();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
